// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- 640x480 @ 60 Hz VGA display timing generator.
//
// Runs on the 50 MHz board clock and makes the 25 MHz pixel rate as a
// one-cycle enable (pixel_tick, high every second clk cycle). Horizontal and
// vertical counters advance on clk edges where pixel_tick is high. Each sync
// and active-video flag is registered and loaded from a decode of the *next*
// counter values, so flags and counters change on the same edge.
//
// Ports:
//   clk          in   50 MHz system clock
//   reset        in   synchronous, active-high reset
//   pixel_tick   out  pixel-rate enable, toggles every clk cycle
//   hsync        out  horizontal sync, level SYNC_POL when asserted
//   vsync        out  vertical sync, level SYNC_POL when asserted
//   video_on     out  high while (pixel_x, pixel_y) is in the active area
//   pixel_x      out  horizontal counter, 0..H_TOTAL-1
//   pixel_y      out  vertical counter, 0..V_TOTAL-1
//   line_start   out  one-clk pulse when pixel_x becomes 0
//   frame_start  out  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)
//
// Reset parks the counters on the last pixel of the frame, so the first
// advance after release lands on (0,0) and raises frame_start.

module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       tick_q, tick_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vid_q, vid_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    always_comb begin
        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);
        x_nxt  = x_wrap ? 10'd0 : x_q + 10'd1;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : y_q + 10'd1;
        end else begin
            y_nxt = y_q;
        end

        // Hold everything between advances; the pulses last one clk only.
        tick_d = ~tick_q;
        x_d    = x_q;
        y_d    = y_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        vid_d  = vid_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;

        // tick_q high means this edge is an advancing edge; decode the
        // values the counters are about to take so flags carry no lag.
        if (tick_q) begin
            x_d   = x_nxt;
            y_d   = y_nxt;
            hs_d  = (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vs_d  = (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            vid_d = (x_nxt < H_ACT) && (y_nxt < V_ACT);
            ls_d  = x_wrap;
            fs_d  = x_wrap && y_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
            x_q    <= H_LAST;
            y_q    <= V_LAST;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            vid_q  <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vid_q  <= vid_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = vid_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen.
// dut_d: default 640x480 timing -- reset sequence, one full line, mid-line reset.
// dut_s: shrunken timing (15x10 totals, active-high sync) -- whole frames,
//        vsync width, active-area count, wrap corners, mid-frame reset.

module tb_vga_sync_gen;

  localparam int SH_DISP  = 8;
  localparam int SH_FRONT = 2;
  localparam int SH_SYNC  = 3;
  localparam int SH_BACK  = 2;
  localparam int SH_TOT   = SH_DISP + SH_FRONT + SH_SYNC + SH_BACK;  // 15
  localparam int SV_DISP  = 6;
  localparam int SV_FRONT = 1;
  localparam int SV_SYNC  = 2;
  localparam int SV_BACK  = 1;
  localparam int SV_TOT   = SV_DISP + SV_FRONT + SV_SYNC + SV_BACK;  // 10
  localparam int S_FRAME  = 2 * SH_TOT * SV_TOT;                     // 300 clk

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  logic       d_tick, d_hs, d_vs, d_vid, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_hs, s_vs, s_vid, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  vga_sync_gen dut_d (
    .clk         (clk),
    .reset       (rst_d),
    .pixel_tick  (d_tick),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .video_on    (d_vid),
    .pixel_x     (d_x),
    .pixel_y     (d_y),
    .line_start  (d_ls),
    .frame_start (d_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY (SH_DISP), .H_FRONT (SH_FRONT), .H_SYNC (SH_SYNC), .H_BACK (SH_BACK),
    .V_DISPLAY (SV_DISP), .V_FRONT (SV_FRONT), .V_SYNC (SV_SYNC), .V_BACK (SV_BACK),
    .SYNC_POL  (1'b1)
  ) dut_s (
    .clk         (clk),
    .reset       (rst_s),
    .pixel_tick  (s_tick),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .video_on    (s_vid),
    .pixel_x     (s_x),
    .pixel_y     (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample 1 time unit after the active edge; inputs are driven there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic tick;
    int   x;
    int   y;
    logic vid;
    logic ls;
    logic fs;
    logic hs;
    logic vs;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test ----------------
  initial begin
    int n;
    int c;
    int hs_cnt, vs_cnt, act_cnt, ls_cnt, vid_cnt, mm;
    int first_hs_x, first_voff_x, fs1_at, fs2_at;
    int ex, ey;
    logic e_ls, e_fs, e_hs, e_vs, e_vid;

    // Reset release on the default-timing instance (sync active-low).
    vecs[0] = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 799, 524, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};  // E1
    vecs[4] = '{1'b0, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};  // E2
    vecs[5] = '{1'b0, 1'b1,   0,   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0,   1,   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1,   1,   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    #1;
    for (int i = 0; i < 8; i++) begin
      rst_d = vecs[i].rst;
      rst_s = vecs[i].rst;
      step();
      chk($sformatf("rst_tbl[%0d].tick", i), int'(d_tick), int'(vecs[i].tick));
      chk($sformatf("rst_tbl[%0d].x", i),    int'(d_x),    vecs[i].x);
      chk($sformatf("rst_tbl[%0d].y", i),    int'(d_y),    vecs[i].y);
      chk($sformatf("rst_tbl[%0d].vid", i),  int'(d_vid),  int'(vecs[i].vid));
      chk($sformatf("rst_tbl[%0d].ls", i),   int'(d_ls),   int'(vecs[i].ls));
      chk($sformatf("rst_tbl[%0d].fs", i),   int'(d_fs),   int'(vecs[i].fs));
      chk($sformatf("rst_tbl[%0d].hs", i),   int'(d_hs),   int'(vecs[i].hs));
      chk($sformatf("rst_tbl[%0d].vs", i),   int'(d_vs),   int'(vecs[i].vs));
    end

    // ---- default timing: one full line (line y=1) ----
    n = 0;
    while (!d_ls && n < 2000) begin step(); n++; end
    chk("d_line_start_timeout", int'(n < 2000), 1);
    chk("d_line_start_x", int'(d_x), 0);
    chk("d_line_start_y", int'(d_y), 1);
    c = 0; hs_cnt = 0; vid_cnt = 0; first_hs_x = -1; first_voff_x = -1;
    do begin
      if (!d_hs) begin
        hs_cnt++;
        if (first_hs_x < 0) first_hs_x = int'(d_x);
      end
      if (d_vid) vid_cnt++;
      else if (first_voff_x < 0) first_voff_x = int'(d_x);
      c++;
      step();
    end while (!d_ls && c < 2000);
    chk("d_line_period", c, 1600);
    chk("d_hsync_width", hs_cnt, 192);
    chk("d_hsync_first_x", first_hs_x, 656);
    chk("d_video_active_cycles", vid_cnt, 1280);
    chk("d_video_off_first_x", first_voff_x, 640);
    chk("d_next_line_y", int'(d_y), 2);

    // ---- default timing: reset mid-line at x=300 ----
    n = 0;
    while (int'(d_x) != 300 && n < 2000) begin step(); n++; end
    chk("d_midreset_timeout", int'(n < 2000), 1);
    chk("d_midreset_vid_before", int'(d_vid), 1);
    rst_d = 1'b1;
    step();
    chk("d_midreset.tick", int'(d_tick), 0);
    chk("d_midreset.x", int'(d_x), 799);
    chk("d_midreset.y", int'(d_y), 524);
    chk("d_midreset.vid", int'(d_vid), 0);
    chk("d_midreset.hs", int'(d_hs), 1);
    chk("d_midreset.vs", int'(d_vs), 1);
    rst_d = 1'b0;
    step();
    chk("d_after_rel_e1.tick", int'(d_tick), 1);
    chk("d_after_rel_e1.x", int'(d_x), 799);
    chk("d_after_rel_e1.fs", int'(d_fs), 0);
    step();
    chk("d_after_rel_e2.x", int'(d_x), 0);
    chk("d_after_rel_e2.y", int'(d_y), 0);
    chk("d_after_rel_e2.fs", int'(d_fs), 1);
    chk("d_after_rel_e2.ls", int'(d_ls), 1);
    chk("d_after_rel_e2.vid", int'(d_vid), 1);
    step();
    chk("d_after_rel_e3.fs", int'(d_fs), 0);

    // ---- small timing: two whole frames against a counting model ----
    n = 0;
    while (!s_fs && n < 2 * S_FRAME) begin step(); n++; end
    chk("s_frame_start_timeout", int'(n < 2 * S_FRAME), 1);
    ex = 0; ey = 0; e_ls = 1'b1; e_fs = 1'b1;
    c = 0; fs1_at = -1; fs2_at = -1; mm = 0;
    hs_cnt = 0; vs_cnt = 0; act_cnt = 0; ls_cnt = 0;
    while (c < 2 * S_FRAME) begin
      e_hs  = (ex >= SH_DISP + SH_FRONT) && (ex <= SH_DISP + SH_FRONT + SH_SYNC - 1);
      e_vs  = (ey >= SV_DISP + SV_FRONT) && (ey <= SV_DISP + SV_FRONT + SV_SYNC - 1);
      e_vid = (ex < SH_DISP) && (ey < SV_DISP);
      if (int'(s_x) != ex || int'(s_y) != ey || s_hs != e_hs || s_vs != e_vs ||
          s_vid != e_vid || s_ls != e_ls || s_fs != e_fs) begin
        if (mm == 0)
          $display("s_model first divergence at c=%0d: dut (%0d,%0d) hs%0b vs%0b vid%0b ls%0b fs%0b, model (%0d,%0d) hs%0b vs%0b vid%0b ls%0b fs%0b",
                   c, s_x, s_y, s_hs, s_vs, s_vid, s_ls, s_fs, ex, ey, e_hs, e_vs, e_vid, e_ls, e_fs);
        mm++;
      end
      if (c < S_FRAME) begin
        if (s_hs) hs_cnt++;
        if (s_vs) vs_cnt++;
        if (s_tick && s_vid) act_cnt++;
        if (s_ls) ls_cnt++;
      end
      e_ls = 1'b0; e_fs = 1'b0;
      if (s_tick) begin
        if (ex == SH_TOT - 1) begin
          ex = 0;
          ey = (ey == SV_TOT - 1) ? 0 : ey + 1;
          e_ls = 1'b1;
          e_fs = (ey == 0);
        end else begin
          ex = ex + 1;
        end
      end
      step();
      c++;
      if (s_fs) begin
        if (fs1_at < 0) fs1_at = c;
        else if (fs2_at < 0) fs2_at = c;
      end
    end
    chk("s_model_mismatch_cycles", mm, 0);
    chk("s_frame_period_1", fs1_at, S_FRAME);
    chk("s_frame_period_2", fs2_at, 2 * S_FRAME);
    chk("s_vsync_width", vs_cnt, 2 * SH_TOT * SV_SYNC);
    chk("s_hsync_cycles_per_frame", hs_cnt, 2 * SH_SYNC * SV_TOT);
    chk("s_active_pixels", act_cnt, SH_DISP * SV_DISP);
    chk("s_line_starts_per_frame", ls_cnt, SV_TOT);

    // ---- small timing: line wrap (last x, y=3) -> (0,4), line_start only ----
    n = 0;
    while (!(int'(s_x) == SH_TOT - 1 && int'(s_y) == 3 && s_tick) && n < 2 * S_FRAME) begin
      step(); n++;
    end
    chk("s_wrap_x_timeout", int'(n < 2 * S_FRAME), 1);
    step();
    chk("s_wrap_x.x", int'(s_x), 0);
    chk("s_wrap_x.y", int'(s_y), 4);
    chk("s_wrap_x.ls", int'(s_ls), 1);
    chk("s_wrap_x.fs", int'(s_fs), 0);
    chk("s_wrap_x.vid", int'(s_vid), 1);

    // ---- small timing: frame wrap (last x, last y) -> (0,0), both pulses ----
    n = 0;
    while (!(int'(s_x) == SH_TOT - 1 && int'(s_y) == SV_TOT - 1 && s_tick) && n < 2 * S_FRAME) begin
      step(); n++;
    end
    chk("s_wrap_xy_timeout", int'(n < 2 * S_FRAME), 1);
    step();
    chk("s_wrap_xy.x", int'(s_x), 0);
    chk("s_wrap_xy.y", int'(s_y), 0);
    chk("s_wrap_xy.ls", int'(s_ls), 1);
    chk("s_wrap_xy.fs", int'(s_fs), 1);
    chk("s_wrap_xy.hs", int'(s_hs), 0);
    chk("s_wrap_xy.vs", int'(s_vs), 0);
    chk("s_wrap_xy.vid", int'(s_vid), 1);
    step();
    chk("s_wrap_xy_pulse_width.ls", int'(s_ls), 0);
    chk("s_wrap_xy_pulse_width.fs", int'(s_fs), 0);

    // ---- small timing: reset mid-frame at (4,3) while active ----
    n = 0;
    while (!(int'(s_x) == 4 && int'(s_y) == 3) && n < 2 * S_FRAME) begin step(); n++; end
    chk("s_midreset_timeout", int'(n < 2 * S_FRAME), 1);
    chk("s_midreset_vid_before", int'(s_vid), 1);
    rst_s = 1'b1;
    step();
    chk("s_midreset.tick", int'(s_tick), 0);
    chk("s_midreset.x", int'(s_x), SH_TOT - 1);
    chk("s_midreset.y", int'(s_y), SV_TOT - 1);
    chk("s_midreset.vid", int'(s_vid), 0);
    chk("s_midreset.hs", int'(s_hs), 0);
    chk("s_midreset.vs", int'(s_vs), 0);
    chk("s_midreset.ls", int'(s_ls), 0);
    rst_s = 1'b0;
    step();
    chk("s_after_rel_e1.tick", int'(s_tick), 1);
    chk("s_after_rel_e1.x", int'(s_x), SH_TOT - 1);
    chk("s_after_rel_e1.fs", int'(s_fs), 0);
    step();
    chk("s_after_rel_e2.x", int'(s_x), 0);
    chk("s_after_rel_e2.y", int'(s_y), 0);
    chk("s_after_rel_e2.fs", int'(s_fs), 1);
    chk("s_after_rel_e2.ls", int'(s_ls), 1);
    chk("s_after_rel_e2.vid", int'(s_vid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Display timing generator for the 640x480 @ 60 Hz VGA output. It runs on the 50 MHz board clock and derives the 25 MHz pixel rate internally as a one-cycle clock enable (`pixel_tick`). It produces `hsync`, `vsync`, the active-video flag and the current pixel coordinates. It sits between the board clock input and the game renderer (note lanes, score overlay), which samples `pixel_x`/`pixel_y` on `pixel_tick`.

## Interface
Parameters:
- `H_DISPLAY`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  synchronous, active-high reset
- `pixel_tick`  out  1  pixel-rate enable; high every second `clk` cycle
- `hsync`  out  1  horizontal sync, level `SYNC_POL` when asserted
- `vsync`  out  1  vertical sync, level `SYNC_POL` when asserted
- `video_on`  out  1  high while (`pixel_x`, `pixel_y`) is inside the active area
- `pixel_x`  out  10  horizontal counter, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical counter, 0..V_TOTAL-1
- `line_start`  out  1  one-`clk` pulse when `pixel_x` becomes 0
- `frame_start`  out  1  one-`clk` pulse when (`pixel_x`, `pixel_y`) becomes (0,0)

## Operation
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Tick generator: a 1-bit toggle register drives `pixel_tick` directly. It resets to 0 and inverts every `clk` cycle.
- Counters advance only on a `clk` edge where `pixel_tick` == 1.
  - `pixel_x` increments; at H_TOTAL-1 it wraps to 0.
  - `pixel_y` increments only on the `pixel_x` wrap; at V_TOTAL-1 it wraps to 0.
  - No other transitions occur.
- All outputs are registered, with zero lag relative to the counters. On an advancing edge each flag is loaded from a decode of the next counter values.
  - `hsync` is asserted for `pixel_x` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - `vsync` is asserted for `pixel_y` in [490, 491].
  - `video_on` = (`pixel_x` < 640) && (`pixel_y` < 480).
- `line_start` and `frame_start` are high only on the cycle immediately after the advancing edge that wraps the counter(s). They are 0 on every other cycle.
- Reset values, applied on the next edge after `reset` is sampled high:
  - `pixel_tick` = 0
  - `pixel_x` = 799, `pixel_y` = 524 (last pixel of the frame)
  - `hsync` = `vsync` = ~SYNC_POL (deasserted)
  - `video_on` = 0
  - `line_start` = `frame_start` = 0
- Reset overrides everything, including the cycle it is asserted mid-line or mid-frame. No partial-frame state survives reset.

## Timing
- Post-reset sequence. Edge E0 is the last edge with `reset` = 1.
  - After E1: `pixel_tick` = 1, counters unchanged.
  - After E2: counters = (0,0), `video_on` = 1, `line_start` = `frame_start` = 1, `pixel_tick` = 0.
- Each pixel lasts 2 `clk` cycles (40 ns).
- Line = 1600 `clk` cycles. `hsync` asserted width = 192 cycles. Active region = 1280 cycles per line.
- Frame = 840000 `clk` cycles (59.52 Hz). `vsync` asserted width = 3200 cycles.
- `line_start` period = 1600 cycles. `frame_start` period = 840000 cycles. Each pulse is exactly 1 `clk` wide.
- `pixel_x`/`pixel_y`/flags are stable for the full 2-cycle pixel. The renderer may sample them on either cycle; it must qualify with `pixel_tick` to avoid double counting.
- Wrap corner (799,524) → (0,0): `hsync` and `vsync` both deassert, `video_on` rises, and `line_start` and `frame_start` pulse together, all on the same edge.

## Test plan
- Reset release: hold `reset` 3 cycles, then drop it. Expect `pixel_tick` 0,1,0,1…. After E2 expect (0,0), `video_on` = 1, `frame_start` = `line_start` = 1 for one cycle.
- Horizontal line: run one line from `line_start`. Expect `hsync` = 0 starting when `pixel_x` = 656, lasting 192 cycles. Expect `video_on` = 0 from `pixel_x` = 640. Expect the next `line_start` exactly 1600 cycles later.
- Vertical frame: run two frames. Expect `vsync` = 0 for `pixel_y` in {490, 491}, i.e. 3200 cycles. Expect consecutive `frame_start` pulses 840000 cycles apart.
- Active-area count: over one frame, count `pixel_tick` && `video_on`. Expect exactly 307200.
- Wrap corners:
  - At (799,200), one advance gives (0,201) with `line_start` only.
  - At (799,524), one advance gives (0,0) with both pulses, and `hsync`/`vsync` deasserted.
- Mid-frame reset: assert `reset` for 1 cycle at (300,200) with `video_on` = 1. Expect all reset values on the next edge, then the identical post-reset sequence, with `frame_start` 2 edges after release.
